car_park_exit_controller: RTL and testbench

Exit-side controller of the car park, the counterpart to the entrance controller. It detects a car at the exit lane and waits for an exit code. On a valid code it opens the gate for a bounded time, then closes it. It keeps the shared occupancy count, incremented by admission pulses from the entrance side and decremented by completed exits, and drives the exit lane's lights and two 7-segment displays.

---
 rtl/car_park_pkg.sv | 46 ++++
 rtl/car_park_exit_controller_if.sv | 26 ++
 rtl/car_park_occupancy_counter.sv | 41 ++++
 rtl/car_park_exit_controller.sv | 94 +++++++++
 tb/tb_car_park_exit_controller.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/car_park_pkg.sv
// Shared car-park definitions: exit FSM states, 7-segment glyphs, default exit code
// and the lane light/display decode used by the exit controller.
package car_park_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CODE_WAIT  = 3'd1,
    WRONG_CODE = 3'd2,
    GATE_OPEN  = 3'd3,
    CLEARING   = 3'd4
  } exit_state_e;

  // Active-low segments, bit order gfedcba
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_W_L   = 7'h61;
  localparam logic [6:0] SEG_W_R   = 7'h43;
  localparam logic [6:0] SEG_G     = 7'h42;
  localparam logic [6:0] SEG_O     = 7'h40;

  localparam logic [1:0] DEFAULT_EXIT_CODE = 2'b10;

  typedef struct packed {
    logic       green;
    logic       red;
    logic [6:0] hex1;
    logic [6:0] hex2;
  } lane_display_t;

  localparam lane_display_t DISPLAY_OFF = '{green: 1'b0, red: 1'b0, hex1: SEG_BLANK, hex2: SEG_BLANK};

  function automatic lane_display_t display_for(exit_state_e s);
    lane_display_t d;
    d = DISPLAY_OFF;
    case (s)
      CODE_WAIT:  d = '{green: 1'b0, red: 1'b1, hex1: SEG_E,   hex2: SEG_P};
      WRONG_CODE: d = '{green: 1'b0, red: 1'b1, hex1: SEG_W_L, hex2: SEG_W_R};
      GATE_OPEN,
      CLEARING:   d = '{green: 1'b1, red: 1'b0, hex1: SEG_G,   hex2: SEG_O};
      default:    d = DISPLAY_OFF;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/car_park_exit_controller_if.sv
// Exit-lane signal bundle: sensors and terminal in, gate/lights/displays/occupancy out.
interface car_park_exit_controller_if #(
  parameter int OCC_W = 4
);
  logic             exit_sensor;
  logic             gate_clear_sensor;
  logic             entry_done;
  logic [1:0]       exit_code;
  logic             gate_open;
  logic             green_light;
  logic             red_light;
  logic [6:0]       hex1;
  logic [6:0]       hex2;
  logic [OCC_W-1:0] occupancy;
  logic             full;

  modport slave (
    input  exit_sensor, gate_clear_sensor, entry_done, exit_code,
    output gate_open, green_light, red_light, hex1, hex2, occupancy, full
  );

  modport master (
    output exit_sensor, gate_clear_sensor, entry_done, exit_code,
    input  gate_open, green_light, red_light, hex1, hex2, occupancy, full
  );
endinterface

// File: rtl/car_park_occupancy_counter.sv
// Saturating car counter shared by entrance and exit sides; simultaneous inc/dec cancel.
module car_park_occupancy_counter #(
  parameter int CAPACITY = 8,
  parameter int OCC_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [OCC_W-1:0] occupancy,
  output logic             full
);

  localparam logic [OCC_W-1:0] CAP = OCC_W'(CAPACITY);

  logic [OCC_W-1:0] occupancy_q, occupancy_d;
  logic             full_q, full_d;

  always_comb begin
    occupancy_d = occupancy_q;
    if (inc && !dec && occupancy_q != CAP)
      occupancy_d = occupancy_q + 1'b1;
    else if (dec && !inc && occupancy_q != '0)
      occupancy_d = occupancy_q - 1'b1;
    full_d = (occupancy_d == CAP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy_q <= '0;
      full_q      <= 1'b0;
    end else begin
      occupancy_q <= occupancy_d;
      full_q      <= full_d;
    end
  end

  assign occupancy = occupancy_q;
  assign full      = full_q;

endmodule

// File: rtl/car_park_exit_controller.sv
// Exit-lane controller: code check, bounded gate opening, clearance tracking,
// registered lane lights/displays and the shared occupancy count.
module car_park_exit_controller
  import car_park_pkg::*;
#(
  parameter int         CAPACITY         = 8,
  parameter int         OCC_W            = 4,
  parameter int         PAY_WAIT         = 4,
  parameter int         GATE_OPEN_CYCLES = 6,
  parameter logic [1:0] EXIT_CODE        = DEFAULT_EXIT_CODE
) (
  input logic                        clk,
  input logic                        reset,
  car_park_exit_controller_if.slave  bus
);

  localparam int TMR_MAX = (PAY_WAIT > GATE_OPEN_CYCLES) ? PAY_WAIT : GATE_OPEN_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] PAY_T     = TMR_W'(PAY_WAIT);
  localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'(GATE_OPEN_CYCLES - 1);

  exit_state_e      state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  lane_display_t    disp_q, disp_d;
  logic             exit_pulse;

  always_comb begin
    state_d    = state_q;
    exit_pulse = 1'b0;
    case (state_q)
      IDLE:       if (bus.exit_sensor) state_d = CODE_WAIT;
      CODE_WAIT: begin
        if (!bus.exit_sensor)        state_d = IDLE;
        else if (timer_q == PAY_T)   state_d = (bus.exit_code == EXIT_CODE) ? GATE_OPEN : WRONG_CODE;
      end
      WRONG_CODE: begin
        if (!bus.exit_sensor)                  state_d = IDLE;
        else if (bus.exit_code == EXIT_CODE)   state_d = GATE_OPEN;
      end
      GATE_OPEN: begin
        if (bus.gate_clear_sensor)      state_d = CLEARING;
        else if (timer_q == GATE_LAST)  state_d = IDLE;
      end
      CLEARING: begin
        if (!bus.gate_clear_sensor) begin
          state_d    = IDLE;
          exit_pulse = 1'b1;
        end
      end
      default:    state_d = IDLE;
    endcase

    if (state_d != state_q)
      timer_d = '0;
    else if (state_q == CODE_WAIT || state_q == GATE_OPEN)
      timer_d = timer_q + 1'b1;
    else
      timer_d = '0;

    // Lights follow the current state, so they appear one clock after the transition
    disp_d = display_for(state_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      disp_q  <= DISPLAY_OFF;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      disp_q  <= disp_d;
    end
  end

  assign bus.gate_open   = (state_q == GATE_OPEN) || (state_q == CLEARING);
  assign bus.green_light = disp_q.green;
  assign bus.red_light   = disp_q.red;
  assign bus.hex1        = disp_q.hex1;
  assign bus.hex2        = disp_q.hex2;

  car_park_occupancy_counter #(
    .CAPACITY (CAPACITY),
    .OCC_W    (OCC_W)
  ) u_occupancy (
    .clk       (clk),
    .reset     (reset),
    .inc       (bus.entry_done),
    .dec       (exit_pulse),
    .occupancy (bus.occupancy),
    .full      (bus.full)
  );

endmodule

// File: tb/tb_car_park_exit_controller.sv
// Scoreboard bench for the exit controller: a cycle model pushes expected outputs
// per clock, compared against the DUT one time unit after each rising edge.
module tb_car_park_exit_controller;

  logic clk;
  logic reset;

  car_park_exit_controller_if #(.OCC_W(4)) bus ();

  car_park_exit_controller #(
    .CAPACITY         (8),
    .OCC_W            (4),
    .PAY_WAIT         (4),
    .GATE_OPEN_CYCLES (6),
    .EXIT_CODE        (2'b10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       go;
    logic       grn;
    logic       red;
    logic [6:0] h1;
    logic [6:0] h2;
    logic [3:0] occ;
    logic       full;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: 0 idle, 1 code wait, 2 wrong code, 3 gate open, 4 clearing
  int m_st, m_tmr, m_occ;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_st = 0; m_tmr = 0; m_occ = 0;
    sb.delete();
  endtask

  task automatic model_edge(input logic s, input logic c, input logic e, input logic [1:0] code);
    int   ns;
    logic xp;
    exp_t x;
    xp = (m_st == 4) && !c;
    ns = m_st;
    case (m_st)
      0: if (s) ns = 1;
      1: if (!s) ns = 0; else if (m_tmr == 4) ns = (code == 2'b10) ? 3 : 2;
      2: if (!s) ns = 0; else if (code == 2'b10) ns = 3;
      3: if (c) ns = 4; else if (m_tmr == 5) ns = 0;
      4: if (!c) ns = 0;
      default: ns = 0;
    endcase
    x.grn = (m_st >= 3);
    x.red = (m_st == 1) || (m_st == 2);
    case (m_st)
      1:       begin x.h1 = 7'h06; x.h2 = 7'h0C; end
      2:       begin x.h1 = 7'h61; x.h2 = 7'h43; end
      3, 4:    begin x.h1 = 7'h42; x.h2 = 7'h40; end
      default: begin x.h1 = 7'h7F; x.h2 = 7'h7F; end
    endcase
    if (e && !xp && m_occ < 8) m_occ++;
    else if (xp && !e && m_occ > 0) m_occ--;
    if (ns != m_st) m_tmr = 0;
    else if (m_st == 1 || m_st == 3) m_tmr++;
    else m_tmr = 0;
    m_st   = ns;
    x.go   = (ns == 3) || (ns == 4);
    x.occ  = 4'(m_occ);
    x.full = (m_occ == 8);
    sb.push_back(x);
  endtask

  task automatic cycle(input logic s, input logic c, input logic e, input logic [1:0] code);
    exp_t x;
    bus.exit_sensor       = s;
    bus.gate_clear_sensor = c;
    bus.entry_done        = e;
    bus.exit_code         = code;
    model_edge(s, c, e, code);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      check("gate_open",   32'(bus.gate_open),   32'(x.go));
      check("green_light", 32'(bus.green_light), 32'(x.grn));
      check("red_light",   32'(bus.red_light),   32'(x.red));
      check("hex1",        32'(bus.hex1),        32'(x.h1));
      check("hex2",        32'(bus.hex2),        32'(x.h2));
      check("occupancy",   32'(bus.occupancy),   32'(x.occ));
      check("full",        32'(bus.full),        32'(x.full));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_gate_open", 32'(bus.gate_open),   32'd0);
    check("rst_green",     32'(bus.green_light), 32'd0);
    check("rst_red",       32'(bus.red_light),   32'd0);
    check("rst_hex1",      32'(bus.hex1),        32'h7F);
    check("rst_hex2",      32'(bus.hex2),        32'h7F);
    check("rst_occupancy", 32'(bus.occupancy),   32'd0);
    check("rst_full",      32'(bus.full),        32'd0);
    bus.exit_sensor = 1'b0; bus.gate_clear_sensor = 1'b0;
    bus.entry_done  = 1'b0; bus.exit_code         = 2'b00;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Drive a car through a correct-code exit; entry_done optionally coincides with the exit pulse
  task automatic good_exit(input logic entry_at_exit);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 2'b10);
    check("opened_after_pay_wait", 32'(bus.gate_open), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 2'b10);
    cycle(1'b0, 1'b1, 1'b0, 2'b00);
    cycle(1'b0, 1'b0, entry_at_exit, 2'b00);
    idle(2);
  endtask

  int go_cnt;

  initial begin
    reset = 1'b0;
    bus.exit_sensor = 1'b0; bus.gate_clear_sensor = 1'b0;
    bus.entry_done  = 1'b0; bus.exit_code         = 2'b00;
    #12;
    do_reset();

    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 2'b00);
      idle(1);
    end
    check("occ_after_3_entries", 32'(bus.occupancy), 32'd3);

    good_exit(1'b0);
    check("occ_after_exit", 32'(bus.occupancy), 32'd2);

    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 2'b01);
    check("wrong_code_red",  32'(bus.red_light), 32'd1);
    check("wrong_code_hex1", 32'(bus.hex1),      32'h61);
    cycle(1'b1, 1'b0, 1'b0, 2'b10);
    go_cnt = int'(bus.gate_open);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 2'b00);
      go_cnt += int'(bus.gate_open);
    end
    check("timeout_open_cycles", 32'(go_cnt), 32'd6);
    check("timeout_occ_kept", 32'(bus.occupancy), 32'd2);

    go_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 2'b10);
      go_cnt += int'(bus.gate_open);
    end
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 2'b10);
      go_cnt += int'(bus.gate_open);
    end
    check("backout_never_open", 32'(go_cnt), 32'd0);

    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 2'b00);
      idle(1);
    end
    check("full_occ", 32'(bus.occupancy), 32'd8);
    check("full_flag", 32'(bus.full), 32'd1);

    good_exit(1'b1);
    check("coincident_at_cap", 32'(bus.occupancy), 32'd8);

    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, 2'b10);
    check("mid_gate_open", 32'(bus.gate_open), 32'd1);
    #2;
    do_reset();

    good_exit(1'b0);
    check("exit_at_zero_occ", 32'(bus.occupancy), 32'd0);
    check("exit_at_zero_full", 32'(bus.full), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
